// File: rtl/lgn_pkg.sv
// Shared widths and state encoding for the LGN category scorer.
package lgn_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      SCAN  = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic int lgn_idx_w(input int categories);
      return ($clog2(categories) < 1) ? 1 : $clog2(categories);
   endfunction

   function automatic int lgn_sum_w(input int bits_per_category);
      return $clog2(bits_per_category + 1);
   endfunction

   function automatic int lgn_beats(input int bits_per_category, input int chunk);
      return (bits_per_category + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/lgn_chunk_popcount.sv
// Popcount of one CHUNK-bit slice, counting only the low valid_cnt bit positions.
module lgn_chunk_popcount #(
   parameter int CHUNK = 32,
   localparam int CNT_W = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] bits,
   input  logic [CNT_W-1:0] valid_cnt,
   output logic [CNT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (CNT_W'(i) < valid_cnt) begin
            count = count + CNT_W'(bits[i]);
         end
      end
   end

endmodule

// File: rtl/lgn_category_scorer.sv
// Beat-serial popcount accumulation with a sequential arg-max scan and valid/ready result.
// Optional best-minus-second margin output is built when LGN_SCORER_MARGIN_EN is defined.
module lgn_category_scorer
   import lgn_pkg::*;
#(
   parameter int CATEGORIES        = 10,
   parameter int BITS_PER_CATEGORY = 800,
   parameter int CHUNK             = 32,
   localparam int IDX_W            = lgn_idx_w(CATEGORIES),
   localparam int SUM_W            = lgn_sum_w(BITS_PER_CATEGORY)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CATEGORIES*CHUNK-1:0]   in_bits,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [IDX_W-1:0]              out_index,
   output logic [SUM_W-1:0]              out_value,
   output logic [SUM_W-1:0]              out_margin
);

   localparam int BEATS    = lgn_beats(BITS_PER_CATEGORY, CHUNK);
   localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W    = $clog2(CHUNK + 1);
   localparam int LAST_CNT = BITS_PER_CATEGORY - (BEATS - 1) * CHUNK;
   localparam int K_W      = $clog2(CATEGORIES + 1);

   state_t             state_q, state_d;
   logic [BEAT_W-1:0]  beat_q;
   logic [K_W-1:0]     k_q;
   logic [SUM_W-1:0]   acc_q [CATEGORIES];
   logic [CNT_W-1:0]   pc [CATEGORIES];
   logic [CNT_W-1:0]   valid_cnt;
   logic [SUM_W-1:0]   cur;
   logic [SUM_W-1:0]   best_q;
   logic [IDX_W-1:0]   idx_q;
   logic               final_beat;
   logic               scan_end;
   logic               out_valid_q;
   logic [IDX_W-1:0]   out_index_q;
   logic [SUM_W-1:0]   out_value_q;
`ifdef LGN_SCORER_MARGIN_EN
   logic [SUM_W-1:0]   second_q;
   logic [SUM_W-1:0]   out_margin_q;
`endif

   assign final_beat = (beat_q == BEAT_W'(BEATS - 1));
   assign scan_end   = (k_q == K_W'(CATEGORIES));
   // Padding positions beyond BITS_PER_CATEGORY in the last beat never count.
   assign valid_cnt  = final_beat ? CNT_W'(LAST_CNT) : CNT_W'(CHUNK);

   for (genvar c = 0; c < CATEGORIES; c++) begin : g_pc
      lgn_chunk_popcount #(.CHUNK(CHUNK)) u_pc (
         .bits      (in_bits[c*CHUNK +: CHUNK]),
         .valid_cnt (valid_cnt),
         .count     (pc[c])
      );
   end

   always_comb begin
      cur = '0;
      for (int c = 0; c < CATEGORIES; c++) begin
         if (K_W'(c) == k_q) cur = acc_q[c];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (in_valid && final_beat) state_d = SCAN;
         SCAN:    if (scan_end) state_d = DONE;
         DONE:    if (out_ready) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
      if (clear) state_d = ACCUM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q      <= '0;
         k_q         <= '0;
         best_q      <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_value_q <= '0;
         for (int c = 0; c < CATEGORIES; c++) acc_q[c] <= '0;
`ifdef LGN_SCORER_MARGIN_EN
         second_q     <= '0;
         out_margin_q <= '0;
`endif
      end else if (clear) begin
         beat_q      <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         for (int c = 0; c < CATEGORIES; c++) acc_q[c] <= '0;
      end else begin
         case (state_q)
            ACCUM: begin
               k_q <= '0;
               if (in_valid) begin
                  for (int c = 0; c < CATEGORIES; c++) acc_q[c] <= acc_q[c] + SUM_W'(pc[c]);
                  beat_q <= final_beat ? '0 : beat_q + 1'b1;
               end
            end
            SCAN: begin
               k_q <= k_q + 1'b1;
               if (k_q == '0) begin
                  best_q <= cur;
                  idx_q  <= '0;
`ifdef LGN_SCORER_MARGIN_EN
                  second_q <= '0;
`endif
               end else if (!scan_end) begin
                  // Strict compare keeps the lowest index on ties.
                  if (cur > best_q) begin
                     best_q <= cur;
                     idx_q  <= IDX_W'(k_q);
`ifdef LGN_SCORER_MARGIN_EN
                     second_q <= best_q;
                  end else if (cur > second_q) begin
                     second_q <= cur;
`endif
                  end
               end else begin
                  out_valid_q <= 1'b1;
                  out_index_q <= idx_q;
                  out_value_q <= best_q;
`ifdef LGN_SCORER_MARGIN_EN
                  out_margin_q <= best_q - second_q;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  for (int c = 0; c < CATEGORIES; c++) acc_q[c] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = out_valid_q;
   assign out_index = out_index_q;
   assign out_value = out_value_q;
`ifdef LGN_SCORER_MARGIN_EN
   assign out_margin = out_margin_q;
`else
   assign out_margin = '0;
`endif

endmodule

// File: tb/tb_lgn_category_scorer.sv
// Scoreboard bench for lgn_category_scorer: default build (10/800/32) and a small 4/50/16 build.
// Expected margins follow LGN_SCORER_MARGIN_EN (0 when the macro is undefined).
module tb_lgn_category_scorer;

   typedef struct {
      int idx;
      int value;
      int margin;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         clear_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b1;
   logic         in_ready_a, out_valid_a;
   logic [319:0] in_bits_a = '0;
   logic [3:0]   out_index_a;
   logic [9:0]   out_value_a, out_margin_a;

   logic         clear_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b1;
   logic         in_ready_b, out_valid_b;
   logic [63:0]  in_bits_b = '0;
   logic [1:0]   out_index_b;
   logic [5:0]   out_value_b, out_margin_b;

   lgn_category_scorer u_a (
      .clk(clk), .rst_n(rst_n), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_bits(in_bits_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_index(out_index_a), .out_value(out_value_a), .out_margin(out_margin_a)
   );

   lgn_category_scorer #(.CATEGORIES(4), .BITS_PER_CATEGORY(50), .CHUNK(16)) u_b (
      .clk(clk), .rst_n(rst_n), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_bits(in_bits_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_index(out_index_b), .out_value(out_value_b), .out_margin(out_margin_b)
   );

   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_a[$];
   exp_t exp_b[$];

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int em(input int m);
`ifdef LGN_SCORER_MARGIN_EN
      return m;
`else
      return 0;
`endif
   endfunction

   function automatic exp_t mk_exp(input int i, input int v, input int m);
      exp_t e;
      e.idx = i;
      e.value = v;
      e.margin = em(m);
      return e;
   endfunction

   function automatic logic [319:0] mk_a(input int ones[10]);
      logic [319:0] v;
      logic [31:0]  s;
      v = '0;
      for (int c = 0; c < 10; c++) begin
         s = (ones[c] >= 32) ? 32'hFFFF_FFFF : ((32'h1 << ones[c]) - 32'h1);
         v[c*32 +: 32] = s;
      end
      return v;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid_a && out_ready_a) begin
         if (exp_a.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL a_unexpected: result idx %0d value %0d with no expectation", out_index_a, out_value_a);
         end else begin
            e = exp_a.pop_front();
            chk("a_index", int'(out_index_a), e.idx);
            chk("a_value", int'(out_value_a), e.value);
            chk("a_margin", int'(out_margin_a), e.margin);
         end
      end
      if (rst_n && out_valid_b && out_ready_b) begin
         if (exp_b.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL b_unexpected: result idx %0d value %0d with no expectation", out_index_b, out_value_b);
         end else begin
            e = exp_b.pop_front();
            chk("b_index", int'(out_index_b), e.idx);
            chk("b_value", int'(out_value_b), e.value);
            chk("b_margin", int'(out_margin_b), e.margin);
         end
      end
   end

   // Called just after an active edge; leaves just after the edge that took the last beat.
   task automatic run_a(input int ones[10], input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         in_bits_a  = mk_a(ones);
         in_valid_a = 1'b1;
         @(posedge clk); #1;
      end
      in_valid_a = 1'b0;
   endtask

   task automatic run_b(input logic [63:0] beats[4]);
      for (int b = 0; b < 4; b++) begin
         in_bits_b  = beats[b];
         in_valid_b = 1'b1;
         @(posedge clk); #1;
      end
      in_valid_b = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, exp_a.size() + exp_b.size(), 0);
   endtask

   task automatic wait_valid_a(input string name);
      int n;
      n = 0;
      while (!out_valid_a && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, int'(out_valid_a), 1);
   endtask

   initial begin
      int o[10];
      logic [63:0] bb[4];

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready_a), 1);
      chk("rst_out_valid", int'(out_valid_a), 0);
      chk("rst_out_index", int'(out_index_a), 0);
      chk("rst_out_value", int'(out_value_a), 0);
      chk("rst_out_margin", int'(out_margin_a), 0);
      chk("rst_b_in_ready", int'(in_ready_b), 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Class 3 all-ones, others 16 per beat, with latency and scan-state checks
      o = '{16, 16, 16, 32, 16, 16, 16, 16, 16, 16};
      exp_a.push_back(mk_exp(3, 800, 400));
      run_a(o, 25);
      repeat (5) @(posedge clk);
      #1;
      chk("scan_in_ready", int'(in_ready_a), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("lat_early", int'(out_valid_a), 0);
      @(posedge clk); #1;
      chk("lat_valid", int'(out_valid_a), 1);
      drain("drain_basic");
      chk("post_hs_in_ready", int'(in_ready_a), 1);

      // Tie between classes 2 and 7
      o = '{4, 4, 20, 4, 4, 4, 4, 20, 4, 4};
      exp_a.push_back(mk_exp(2, 500, 0));
      run_a(o, 25);
      drain("drain_tie");

      // Padding bits masked in the small build
      bb = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      exp_b.push_back(mk_exp(0, 50, 0));
      run_b(bb);
      drain("drain_pad_all");
      bb = '{64'hFFFF_0000_0000_0001, 64'hFFFF_0000_0000_0001,
             64'hFFFF_0000_0000_0001, 64'hFFFF_0000_FFFC_0001};
      exp_b.push_back(mk_exp(3, 50, 46));
      run_b(bb);
      drain("drain_pad_mix");

      // Back-pressure in DONE
      out_ready_a = 1'b0;
      o = '{8, 32, 8, 8, 8, 8, 8, 8, 8, 8};
      exp_a.push_back(mk_exp(1, 800, 600));
      run_a(o, 25);
      wait_valid_a("bp_valid");
      o = '{32, 32, 32, 32, 32, 32, 32, 32, 32, 32};
      in_bits_a  = mk_a(o);
      in_valid_a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (i % 5 == 4) begin
            chk("bp_hold_valid", int'(out_valid_a), 1);
            chk("bp_hold_index", int'(out_index_a), 1);
            chk("bp_hold_value", int'(out_value_a), 800);
            chk("bp_in_ready", int'(in_ready_a), 0);
         end
      end
      in_valid_a  = 1'b0;
      out_ready_a = 1'b1;
      drain("drain_bp");
      chk("bp_keep_value", int'(out_value_a), 800);
      chk("bp_out_valid_low", int'(out_valid_a), 0);
      o = '{32, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      exp_a.push_back(mk_exp(0, 800, 800));
      run_a(o, 25);
      drain("drain_after_bp");

      // Abort with clear after 10 beats
      o = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32};
      run_a(o, 10);
      clear_a = 1'b1;
      @(posedge clk); #1;
      clear_a = 1'b0;
      chk("clr_in_ready", int'(in_ready_a), 1);
      chk("clr_out_valid", int'(out_valid_a), 0);
      exp_a.push_back(mk_exp(5, 640, 390));
      o = '{10, 10, 10, 10, 10, 32, 10, 10, 10, 10};
      run_a(o, 20);
      o = '{10, 10, 10, 10, 10, 0, 10, 10, 10, 10};
      run_a(o, 5);
      drain("drain_abort");

      // Asynchronous reset during the scan
      o = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32};
      run_a(o, 25);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid_a), 0);
      chk("arst_in_ready", int'(in_ready_a), 1);
      chk("arst_out_value", int'(out_value_a), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      o = '{31, 31, 31, 31, 31, 31, 31, 31, 32, 31};
      exp_a.push_back(mk_exp(8, 800, 25));
      run_a(o, 25);
      drain("drain_after_arst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lgn_category_scorer.md
Name: lgn_category_scorer

Overview:
- Time-multiplexed successor to the combinational popcount and arg-max head of the LGN classifier.
- Accepts per-category output bits of the logic-gate network in beats of CHUNK bits per category and accumulates one popcount per category.
- After the last beat, runs a sequential arg-max scan and presents the winning class index and score through a valid/ready handshake.
- Sits between the net and the display/readout logic; the seven-segment decode stays outside.

Parameters:
- CATEGORIES, 10, number of classes (≥2).
- BITS_PER_CATEGORY, 800, output bits per class per inference.
- CHUNK, 32, bits per class delivered per beat (1..BITS_PER_CATEGORY).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clear  in  1  synchronous abort; zeroes accumulators and returns to ACCUM.
- in_valid  in  1  beat present.
- in_ready  out  1  block can accept a beat.
- in_bits  in  CATEGORIES*CHUNK  beat data; class c occupies [c*CHUNK +: CHUNK].
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_index  out  IDX_W  winning class.
- out_value  out  SUM_W  winning popcount.
- out_margin  out  SUM_W  best minus second-best (see Optional Feature).

Behaviour:
- Widths:
  - IDX_W = max(1, $clog2(CATEGORIES)).
  - SUM_W = $clog2(BITS_PER_CATEGORY+1), so a full count never overflows.
  - BEATS = ceil(BITS_PER_CATEGORY/CHUNK).
- States: ACCUM, SCAN, DONE. Reset state is ACCUM.
- Reset values: all accumulators 0, beat counter 0, out_valid 0, out_index 0, out_value 0, out_margin 0, in_ready 1.
- ACCUM:
  - in_ready=1.
  - A beat is accepted on each edge where in_valid=1: acc[c] += popcount(slice c).
  - On the final beat (counter = BEATS-1), bits at slice positions ≥ (BITS_PER_CATEGORY - (BEATS-1)*CHUNK) are masked to 0.
  - After the final beat is accepted: beat counter resets to 0, state goes to SCAN.
- SCAN:
  - in_ready=0. Scan index k runs 0..CATEGORIES-1, one class per cycle.
  - k=0 loads best=acc[0], idx=0, second=0.
  - For k>0: if acc[k] > best, then second=best, best=acc[k], idx=k; else if acc[k] > second, then second=acc[k].
  - Ties resolve to the lowest index.
  - After k=CATEGORIES-1, go to DONE.
- Latency: if the last beat is accepted at edge T, the result registers update and out_valid rises at edge T+CATEGORIES+1.
- DONE:
  - out_valid=1; outputs stable until the handshake.
  - On out_valid & out_ready: out_valid drops, accumulators clear, state returns to ACCUM. in_ready rises the cycle after.
  - out_index, out_value and out_margin keep their last values after the handshake until the next result.
- clear:
  - Has priority over beat acceptance, scan and handshake in any state.
  - Next state ACCUM, accumulators and counter 0, out_valid 0.
  - A result in DONE is discarded.
- rst_n low mid-operation: immediate return to reset values; the partial inference is lost.
- in_valid in SCAN/DONE is ignored; no beat is consumed.
- An all-zero input yields index 0, value 0, margin 0.

Optional Feature:
- Macro: LGN_SCORER_MARGIN_EN.
- Defined: the second-best register exists, and out_margin = best - second, registered together with out_value.
- Undefined: no second-best logic is built; out_margin is tied to 0.
- The port list is identical in both builds.

Decomposition:
- Package lgn_pkg holds:
  - localparam functions for IDX_W, SUM_W and BEATS;
  - the state enum typedef (ACCUM/SCAN/DONE).
- One natural sub-module, lgn_chunk_popcount: masked popcount of one CHUNK slice with a valid-bit count input. It is instantiated CATEGORIES times.

Test Plan:
- Default params; 25 beats where class 3 gets all-ones and others get 16 ones/beat → out_index=3, out_value=800, margin=400; out_valid rises 11 edges after the last beat.
- CATEGORIES=4, BITS_PER_CATEGORY=50, CHUNK=16; all-ones input including the 14 padding bits of beat 4 → every class scores 50 (not 64); out_index=0, margin=0.
- Tie test: classes 2 and 7 each score 500, all others 100 → out_index=2, out_value=500, margin=0.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE → outputs stable, in_ready=0, in_valid beats ignored; then out_ready=1 → handshake, and the next inference starts from zero.
- Abort: assert clear after 10 beats, then run a full clean inference with class 5 winning at 640 → result unaffected by the aborted beats.
- Async reset: drop rst_n during SCAN → out_valid=0 and in_ready=1 immediately; a subsequent inference is correct.
- Build without LGN_SCORER_MARGIN_EN → out_margin stays 0 for all scenarios above.
